// File: rtl/rot_message_encoder.sv
// ============================================================================
//  Module      : rot_message_encoder
//  Description : Streaming byte encoder. Each byte is rotated left by a
//                per-position key nibble and buffered in an output FIFO.
//                Optional per-frame XOR checksum byte: ENCODER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rot_message_encoder #(
    parameter int KEY_LEN    = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int IDX_W     = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_wr,
    input  logic [4*KEY_LEN-1:0]   key_in,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   busy,
    output logic [IDX_W-1:0]       key_idx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(KEY_LEN - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_NOKEY = 2'd0,
        S_READY = 2'd1,
        S_FRAME = 2'd2
`ifdef ENCODER_CHECKSUM_EN
        , S_CSUM = 2'd3
`endif
    } state_t;

    state_t             r_state;
    logic [2:0]         r_key [KEY_LEN];
    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_space;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic [8:0]         w_push_word;
    logic [2:0]         w_rot;
    logic [7:0]         w_enc;
    logic [KEY_LEN-1:0] w_unused_key_msb;

    // Bit 3 of every key nibble carries no rotation information.
    generate
        for (genvar i = 0; i < KEY_LEN; i++) begin : g_key_msb
            assign w_unused_key_msb[i] = key_in[4*i+3];
        end
    endgenerate

    assign w_space   = (r_count < c_DEPTH);
    assign in_ready  = ((r_state == S_READY) || (r_state == S_FRAME)) && w_space;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_count != '0);
    assign w_pop     = out_valid && out_ready;
    assign out_data  = r_mem[r_rd_ptr][7:0];
    assign out_last  = r_mem[r_rd_ptr][8];

    assign w_rot = r_key[key_idx];
    assign w_enc = (in_data << w_rot) | (in_data >> (4'd8 - {1'b0, w_rot}));

`ifdef ENCODER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic [7:0] w_csum_next;

    // A frame starts whenever a byte is accepted from READY.
    assign w_csum_next = ((r_state == S_READY) ? 8'h00 : r_csum) ^ in_data;
    assign busy = (r_state == S_FRAME) || (r_state == S_CSUM);

    always_comb begin
        w_push      = 1'b0;
        w_push_word = '0;
        if (w_accept) begin
            w_push      = 1'b1;
            w_push_word = {1'b0, w_enc};
        end else if ((r_state == S_CSUM) && w_space) begin
            w_push      = 1'b1;
            w_push_word = {1'b1, r_csum};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= w_csum_next;
        end
    end
`else
    assign busy = (r_state == S_FRAME);

    always_comb begin
        w_push      = w_accept;
        w_push_word = {in_last, w_enc};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_NOKEY;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            key_idx  <= '0;
            for (int i = 0; i < KEY_LEN; i++) begin
                r_key[i] <= 3'd0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 9'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

            if (w_accept) begin
                key_idx <= (in_last || (key_idx == c_IDX_LAST)) ? '0 : key_idx + 1'b1;
            end

            case (r_state)
                S_NOKEY: begin
                    if (key_wr) begin
                        for (int i = 0; i < KEY_LEN; i++) begin
                            r_key[i] <= key_in[4*i +: 3];
                        end
                        r_state <= S_READY;
                    end
                end
                S_READY: begin
                    // A byte accepted alongside key_wr still sees the old key.
                    if (key_wr) begin
                        for (int i = 0; i < KEY_LEN; i++) begin
                            r_key[i] <= key_in[4*i +: 3];
                        end
                    end
                    if (w_accept) begin
`ifdef ENCODER_CHECKSUM_EN
                        r_state <= in_last ? S_CSUM : S_FRAME;
`else
                        r_state <= in_last ? S_READY : S_FRAME;
`endif
                    end
                end
                S_FRAME: begin
                    if (w_accept && in_last) begin
`ifdef ENCODER_CHECKSUM_EN
                        r_state <= S_CSUM;
`else
                        r_state <= S_READY;
`endif
                    end
                end
`ifdef ENCODER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_space) begin
                        r_state <= S_READY;
                    end
                end
`endif
                default: r_state <= S_NOKEY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rot_message_encoder.sv
// ============================================================================
//  Module      : tb_rot_message_encoder
//  Description : Self-checking bench: vector table plus directed sequences,
//                outputs compared against a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rot_message_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_wr;
    logic [31:0] key_in;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic [2:0]  key_idx;

    rot_message_encoder #(.KEY_LEN(8), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_wr    (key_wr),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy),
        .key_idx   (key_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic [31:0] key;
        logic [7:0]  d;
        logic        last;
        logic [7:0]  exp;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[$];
    logic [7:0] csum = 8'h00;
    logic       in_frame = 1'b0;
    vec_t       vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected FIFO entries for one accepted byte (plus checksum byte if built in).
    task automatic exp_push(input logic [7:0] d, input logic last, input logic [7:0] enc);
`ifdef ENCODER_CHECKSUM_EN
        if (!in_frame) csum = 8'h00;
        csum = csum ^ d;
        q.push_back({1'b0, enc});
        if (last) q.push_back({1'b1, csum});
`else
        q.push_back({last, enc});
`endif
        in_frame = !last;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                chk("out_data", {24'd0, out_data}, {24'd0, q[0][7:0]});
                chk("out_last", {31'd0, out_last}, {31'd0, q[0][8]});
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic load_key(input logic [31:0] k);
        wait_idle();
        key_in = k;
        key_wr = 1'b1;
        @(posedge clk); #1;
        key_wr = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic last, input logic [7:0] enc);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
        else exp_push(d, last, enc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        key_wr   = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_9031, 8'h81, 1'b0, 8'h03};
        vecs[1]  = '{1'b0, 32'h0,         8'h0F, 1'b0, 8'h78};
        vecs[2]  = '{1'b0, 32'h0,         8'hA5, 1'b0, 8'hA5};
        vecs[3]  = '{1'b0, 32'h0,         8'h81, 1'b1, 8'h03};
        vecs[4]  = '{1'b1, 32'h2121_2121, 8'h01, 1'b0, 8'h02};
        vecs[5]  = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h04};
        vecs[6]  = '{1'b0, 32'h0,         8'h01, 1'b1, 8'h02};
        vecs[7]  = '{1'b0, 32'h0,         8'h01, 1'b1, 8'h02};
        vecs[8]  = '{1'b1, 32'h0765_4321, 8'h01, 1'b0, 8'h02};
        vecs[9]  = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h04};
        vecs[10] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h08};
        vecs[11] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h10};
        vecs[12] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h20};
        vecs[13] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h40};
        vecs[14] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h80};
        vecs[15] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h01};
        vecs[16] = '{1'b0, 32'h0,         8'h01, 1'b0, 8'h02};
        vecs[17] = '{1'b0, 32'h0,         8'h01, 1'b1, 8'h04};
        vecs[18] = '{1'b1, 32'h0000_00C4, 8'hA5, 1'b0, 8'h5A};
        vecs[19] = '{1'b0, 32'h0,         8'h3C, 1'b1, 8'hC3};

        rst = 1'b1; key_wr = 1'b0; key_in = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, then bytes offered with no key loaded.
        @(negedge clk);
        chk("rst_out_data", {24'd0, out_data}, 32'h0);
        chk("rst_out_last", {31'd0, out_last}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_key_idx", {29'd0, key_idx}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("nokey_in_ready", {31'd0, in_ready}, 32'h0);
            chk("nokey_out_valid", {31'd0, out_valid}, 32'h0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].ld) load_key(vecs[i].key);
            send(vecs[i].d, vecs[i].last, vecs[i].exp);
            if (vecs[i].last) chk("key_idx_after_last", {29'd0, key_idx}, 32'h0);
        end
        wait_drain();

        // Backpressure: four entries fill the FIFO, the rest wait.
        load_key(32'h0);
        out_ready = 1'b0;
        begin
            int n = 0;
            for (int c = 0; c < 8; c++) begin
                in_valid = 1'b1;
                in_data  = 8'h10 + 8'(n);
                in_last  = 1'b0;
                @(negedge clk);
                if (in_ready) begin
                    exp_push(in_data, 1'b0, in_data);
                    n++;
                end
                @(posedge clk); #1;
            end
            chk("bp_accepts", n, 32'd4);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_full_ready", {31'd0, in_ready}, 32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", {31'd0, in_ready}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("after_pop_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk); #1;
        send(8'h14, 1'b1, 8'h14);
        wait_drain();

        // key_wr mid-frame is ignored; in READY it applies from the next byte.
        load_key(32'h1111_1111);
        send(8'h01, 1'b0, 8'h02);
        chk("frame_busy", {31'd0, busy}, 32'h1);
        key_in = 32'h2222_2222;
        key_wr = 1'b1;
        @(posedge clk); #1;
        key_wr = 1'b0;
        send(8'h01, 1'b1, 8'h02);
        wait_idle();
        key_wr = 1'b1;
        send(8'h01, 1'b0, 8'h02);
        send(8'h01, 1'b1, 8'h04);
        wait_drain();
        wait_idle();
        chk("idle_busy", {31'd0, busy}, 32'h0);

`ifdef ENCODER_CHECKSUM_EN
        load_key(32'h0);
        send(8'h12, 1'b0, 8'h12);
        send(8'h34, 1'b1, 8'h34);
        @(negedge clk);
        chk("csum_in_ready", {31'd0, in_ready}, 32'h0);
        chk("csum_busy", {31'd0, busy}, 32'h1);
        @(posedge clk); #1;
        wait_drain();
`endif

        // Reset mid-frame drops buffered bytes and frame state.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", {31'd0, out_valid}, 32'h1);
        chk("pre_reset_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_frame = 1'b0;
        @(negedge clk);
        chk("post_reset_valid", {31'd0, out_valid}, 32'h0);
        chk("post_reset_busy", {31'd0, busy}, 32'h0);
        chk("post_reset_ready", {31'd0, in_ready}, 32'h0);
        chk("post_reset_idx", {29'd0, key_idx}, 32'h0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        load_key(32'h0000_0001);
        send(8'h81, 1'b1, 8'h03);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
